grid_mover: RTL and testbench
=============================

GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 The block SHALL have parameter GRID_W, default 27, meaning grid columns (x = 0..GRID_W-1).
REQ-002 The block SHALL have parameter GRID_H, default 24, meaning grid rows (y = 0..GRID_H-1).
REQ-003 The block SHALL have parameter X_W, default 8, meaning x coordinate width.
REQ-004 The block SHALL have parameter Y_W, default 7, meaning y coordinate width.
REQ-005 The block SHALL have parameters START_X, default 2, and START_Y, default 1, meaning the reset position.
REQ-006 The block SHALL have parameter STEP_DIV, default 4, meaning clock cycles per step; legal values are >=3.
REQ-007 The block SHALL have parameter WRAP_EN, default 1, meaning edge wrap-around enable.
REQ-008 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  system clock, rising edge; reset  in  1  synchronous active-high reset.
REQ-009 The block SHALL have port en  in  1, meaning step divider advances only while high.
REQ-010 The block SHALL have port dir_in  in  3, meaning requested direction: RIGHT=0, UP=1, LEFT=2, DOWN=3, WAIT=4; codes 5-7 are ignored.
REQ-011 The block SHALL have port map_wall  in  1, meaning a combinational wall flag for cell (map_x, map_y), valid in the same cycle.
REQ-012 The block SHALL have ports map_x  out  X_W and map_y  out  Y_W, meaning the map lookup address.
REQ-013 The block SHALL have ports x_out  out  X_W and y_out  out  Y_W, meaning the registered current position.
REQ-014 The block SHALL have port dir_out  out  3, meaning the registered current heading.
REQ-015 The block SHALL have ports moved  out  1 and blocked  out  1, meaning one-cycle pulses reporting the step result.

Function
REQ-016 Queue register q_dir SHALL load dir_in on every cycle dir_in<=4; dir_in 5-7 SHALL leave q_dir unchanged.
REQ-017 Divider cnt SHALL increment while en=1, wrap STEP_DIV-1->0, and generate tick on that wrap; it SHALL hold while en=0.
REQ-018 FSM states SHALL be IDLE, TURN, FWD; IDLE->TURN on tick; every other IDLE cycle stays in IDLE.
REQ-019 Neighbour of (x,y) SHALL be: RIGHT x+1; LEFT x-1; UP y+1; DOWN y-1; WAIT none.
REQ-020 Leaving the grid SHALL wrap to the opposite edge when WRAP_EN=1 (x GRID_W-1 -> 0, x 0 -> GRID_W-1, y GRID_H-1 -> 0, y 0 -> GRID_H-1); when WRAP_EN=0 it is illegal.
REQ-021 TURN SHALL drive map_x/map_y = neighbour(pos, q_dir). If q_dir!=WAIT, the target is legal, and map_wall=0: pos<=target, dir_out<=q_dir, moved pulses next cycle, and the FSM goes to IDLE. Otherwise the FSM goes to FWD.
REQ-022 FWD SHALL drive map_x/map_y = neighbour(pos, dir_out). If dir_out!=WAIT, the target is legal, and map_wall=0: pos<=target and moved pulses. Otherwise position and heading are held and blocked pulses. The FSM then goes to IDLE.
REQ-023 q_dir=WAIT evaluated in TURN SHALL set dir_out<=WAIT, with no move and no blocked pulse; the FSM SHALL go directly to IDLE.
REQ-024 The q_dir value used in TURN SHALL be the registered value; a dir_in change in the same cycle SHALL take effect at the next tick.
REQ-025 Commit latency from tick SHALL be 1 cycle (turn accepted) or 2 cycles (forward or blocked); exactly one of moved/blocked SHALL pulse per non-WAIT step.
REQ-026 In IDLE, map_x/map_y SHALL equal x_out/y_out.
REQ-027 Illegal targets SHALL NOT depend on map_wall.
REQ-028 Arithmetic SHALL be computed at X_W+1 / Y_W+1 bits so that no underflow aliases into the grid.

Reset
REQ-029 On reset, the block SHALL set x_out=START_X, y_out=START_Y, dir_out=WAIT, q_dir=WAIT, cnt=0, state=IDLE, moved=0, blocked=0.
REQ-030 Reset asserted in TURN or FWD SHALL abort the step with no position change and no pulse.
REQ-031 Reset SHALL dominate en and dir_in in the same cycle.

Structure
REQ-032 Direction codes (RIGHT/UP/LEFT/DOWN/WAIT) and FSM state encodings SHALL live in shared package pacman_pkg, also used by the shaper and ghost logic.
REQ-033 The neighbour/wrap/legality computation SHALL be one combinational sub-module, grid_step, instantiated once with a muxed direction.
REQ-034 The wall map SHALL remain external to this block.

Verification
REQ-035 Reset, then dir_in=RIGHT with open map -> first tick commits x_out 2->3, dir_out=RIGHT, and moved pulses 1 cycle later; subsequent steps occur every 4 cycles.
REQ-036 At x=26 heading RIGHT with WRAP_EN=1 -> x_out=0; with WRAP_EN=0 -> x_out stays 26, blocked=1, and map_wall is ignored.
REQ-037 Heading RIGHT at (5,1), q_dir=UP, wall at (5,2), open at (6,1) -> x_out=6, dir_out=RIGHT, moved 2 cycles after tick; once (6,2) opens, the next tick sets y_out=2, dir_out=UP.
REQ-038 Walls at both (3,1) and (2,2) with dir_out=RIGHT, q_dir=UP -> position holds and blocked pulses once per tick.
REQ-039 en=0 for 10 cycles mid-count -> no steps occur and cnt holds; on resume the remaining count completes before the tick.
REQ-040 Reset asserted on the FWD cycle -> position returns to (2,1) with no moved or blocked pulse; dir_in=7 at any time -> q_dir is unchanged.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared Pac-Man grid types: direction codes and mover FSM state encodings.
// Used by the grid mover, the shaper and the ghost logic.
// Pure declarations; no latency or backpressure of its own.
package pacman_pkg;

    localparam int DIR_W = 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_RIGHT = 3'd0,
        DIR_UP    = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_WAIT  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    // Codes 5-7 are not directions and must not disturb queued state.
    function automatic logic dir_code_valid(input logic [DIR_W-1:0] code);
        return code <= 3'd4;
    endfunction

endpackage

// File: rtl/grid_mover_if.sv
// Bundle between the grid mover and its environment (controls, map, status).
// Purely wiring; no latency.
// No backpressure: the map lookup is answered combinationally in the same cycle.
//   en, dir_in       : step enable and requested direction
//   map_x/map_y      : wall lookup address, map_wall: answer for that cell
//   x_out/y_out      : current position, dir_out: current heading
//   moved/blocked    : one-cycle step result pulses
interface grid_mover_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           en;
    logic [2:0]     dir_in;
    logic           map_wall;
    logic [X_W-1:0] map_x;
    logic [Y_W-1:0] map_y;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [2:0]     dir_out;
    logic           moved;
    logic           blocked;

    // master: the mover itself
    modport master (
        input  en, dir_in, map_wall,
        output map_x, map_y, x_out, y_out, dir_out, moved, blocked
    );

    // slave: whatever drives the mover and owns the wall map
    modport slave (
        output en, dir_in, map_wall,
        input  map_x, map_y, x_out, y_out, dir_out, moved, blocked
    );
endinterface

// File: rtl/grid_step.sv
// Neighbour cell of (x,y) in direction dir, with edge wrap or illegal-target flag.
// Purely combinational, zero latency.
// No backpressure.
//   x, y, dir : current cell and direction
//   nx, ny    : neighbour address (raw out-of-grid value when illegal)
//   legal     : target lies in the grid (always 1 when wrapping is enabled)
module grid_step
    import pacman_pkg::*;
#(
    parameter int GRID_W  = 27,
    parameter int GRID_H  = 24,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int WRAP_EN = 1
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  dir_t           dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           legal
);

    // One extra bit so 0-1 shows up as a set MSB instead of aliasing into the grid.
    localparam logic [X_W:0] X_LAST = (X_W+1)'(GRID_W - 1);
    localparam logic [Y_W:0] Y_LAST = (Y_W+1)'(GRID_H - 1);
    localparam logic [X_W:0] X_ONE  = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE  = (Y_W+1)'(1);

    logic [X_W:0] xs;
    logic [Y_W:0] ys;

    always_comb begin
        xs    = {1'b0, x};
        ys    = {1'b0, y};
        legal = 1'b1;
        case (dir)
            DIR_RIGHT: begin
                xs = {1'b0, x} + X_ONE;
                if (xs > X_LAST) begin
                    if (WRAP_EN != 0) xs = '0;
                    else              legal = 1'b0;
                end
            end
            DIR_LEFT: begin
                xs = {1'b0, x} - X_ONE;
                if (xs[X_W]) begin
                    if (WRAP_EN != 0) xs = X_LAST;
                    else              legal = 1'b0;
                end
            end
            DIR_UP: begin
                ys = {1'b0, y} + Y_ONE;
                if (ys > Y_LAST) begin
                    if (WRAP_EN != 0) ys = '0;
                    else              legal = 1'b0;
                end
            end
            DIR_DOWN: begin
                ys = {1'b0, y} - Y_ONE;
                if (ys[Y_W]) begin
                    if (WRAP_EN != 0) ys = Y_LAST;
                    else              legal = 1'b0;
                end
            end
            default: ;  // WAIT: stay on the current cell
        endcase
        nx = xs[X_W-1:0];
        ny = ys[Y_W-1:0];
    end

endmodule

// File: rtl/grid_mover.sv
// Steps a sprite across a wall map every STEP_DIV enabled cycles, preferring the queued turn.
// Latency: commit 1 cycle after tick for an accepted turn, 2 cycles for forward/blocked.
// No backpressure: the wall map must answer map_x/map_y combinationally in the same cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : grid_mover_if master (en, dir_in, map_*, x_out, y_out, dir_out, moved, blocked)
module grid_mover
    import pacman_pkg::*;
#(
    parameter int GRID_W   = 27,
    parameter int GRID_H   = 24,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int START_X  = 2,
    parameter int START_Y  = 1,
    parameter int STEP_DIV = 4,
    parameter int WRAP_EN  = 1
) (
    input  logic         clock,
    input  logic         reset,
    grid_mover_if.master bus
);

    localparam int                CNT_W    = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);

    state_t          state, state_nxt;
    dir_t            q_dir;
    dir_t            dir_q, dir_nxt;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [CNT_W-1:0] cnt;
    logic            tick;
    logic            moved_q, blocked_q;
    logic            moved_nxt, blocked_nxt;
    logic            pos_ld, dir_ld;

    dir_t            step_dir;
    logic [X_W-1:0]  nx;
    logic [Y_W-1:0]  ny;
    logic            legal;
    logic            open;

    assign tick = bus.en && (cnt == CNT_LAST);

    // One neighbour calculator shared by both FSM phases; WAIT in IDLE
    // makes the lookup address equal the current position.
    always_comb begin
        case (state)
            ST_TURN: step_dir = q_dir;
            ST_FWD:  step_dir = dir_q;
            default: step_dir = DIR_WAIT;
        endcase
    end

    grid_step #(
        .GRID_W  (GRID_W),
        .GRID_H  (GRID_H),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .WRAP_EN (WRAP_EN)
    ) u_step (
        .x     (x_q),
        .y     (y_q),
        .dir   (step_dir),
        .nx    (nx),
        .ny    (ny),
        .legal (legal)
    );

    // Off-grid targets are blocked whatever the map says about that address.
    assign open = legal && !bus.map_wall;

    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir_q;
        pos_ld      = 1'b0;
        dir_ld      = 1'b0;
        moved_nxt   = 1'b0;
        blocked_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_TURN;
            end
            ST_TURN: begin
                if (q_dir == DIR_WAIT) begin
                    dir_ld    = 1'b1;
                    dir_nxt   = DIR_WAIT;
                    state_nxt = ST_IDLE;
                end else if (open) begin
                    pos_ld    = 1'b1;
                    dir_ld    = 1'b1;
                    dir_nxt   = q_dir;
                    moved_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_FWD;
                end
            end
            ST_FWD: begin
                if (dir_q != DIR_WAIT && open) begin
                    pos_ld    = 1'b1;
                    moved_nxt = 1'b1;
                end else begin
                    blocked_nxt = 1'b1;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            q_dir     <= DIR_WAIT;
            dir_q     <= DIR_WAIT;
            x_q       <= X_W'(START_X);
            y_q       <= Y_W'(START_Y);
            cnt       <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            moved_q   <= moved_nxt;
            blocked_q <= blocked_nxt;
            if (bus.en) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (dir_code_valid(bus.dir_in)) q_dir <= dir_t'(bus.dir_in);
            if (pos_ld) begin
                x_q <= nx;
                y_q <= ny;
            end
            if (dir_ld) dir_q <= dir_nxt;
        end
    end

    assign bus.map_x   = nx;
    assign bus.map_y   = ny;
    assign bus.x_out   = x_q;
    assign bus.y_out   = y_q;
    assign bus.dir_out = dir_q;
    assign bus.moved   = moved_q;
    assign bus.blocked = blocked_q;

endmodule

// File: tb/tb_grid_mover.sv
// Bench for grid_mover: a wrapping and a non-wrapping instance share stimulus and a
// wall map; a per-instance reference model built from the stepping rules predicts
// every cycle, plus directed latency/boundary scenarios and a random phase.
module tb_grid_mover;

    localparam int GW = 27, GH = 24, XW = 8, YW = 7, DIV = 4, SX = 2, SY = 1;
    localparam int R = 0, U = 1, L = 2, D = 3, W = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] dir_in;
    logic [GW*GH-1:0] walls;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    grid_mover_if #(.X_W(XW), .Y_W(YW)) ifa ();
    grid_mover_if #(.X_W(XW), .Y_W(YW)) ifb ();

    grid_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .START_X(SX), .START_Y(SY),
                 .STEP_DIV(DIV), .WRAP_EN(1))
        u_dut_a (.clock(clock), .reset(reset), .bus(ifa));

    grid_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .START_X(SX), .START_Y(SY),
                 .STEP_DIV(DIV), .WRAP_EN(0))
        u_dut_b (.clock(clock), .reset(reset), .bus(ifb));

    // Combinational wall map; addresses outside the grid read as open.
    always_comb begin
        ifa.en       = en;
        ifa.dir_in   = dir_in;
        ifb.en       = en;
        ifb.dir_in   = dir_in;
        ifa.map_wall = 1'b0;
        ifb.map_wall = 1'b0;
        if (int'(ifa.map_x) < GW && int'(ifa.map_y) < GH)
            ifa.map_wall = walls[10'(int'(ifa.map_y) * GW + int'(ifa.map_x))];
        if (int'(ifb.map_x) < GW && int'(ifb.map_y) < GH)
            ifb.map_wall = walls[10'(int'(ifb.map_y) * GW + int'(ifb.map_x))];
    end

    // ---------------- reference model ----------------
    int mx [2], my [2], md [2], mq [2], mc [2], mph [2];
    bit mmv [2], mbl [2];
    bit wrapf [2];

    function automatic bit wall_at(input int x, input int y);
        if (x < 0 || x >= GW || y < 0 || y >= GH) return 1'b0;
        return walls[10'(y * GW + x)];
    endfunction

    task automatic set_wall(input int x, input int y, input bit v);
        walls[10'(y * GW + x)] = v;
    endtask

    // Neighbour on a torus (wrap) or on a bounded board (no wrap).
    function automatic void nb(input int x, input int y, input int d, input bit wrap,
                               output int nx, output int ny, output bit legal);
        int dx, dy;
        dx = (d == R) ? 1 : (d == L) ? -1 : 0;
        dy = (d == U) ? 1 : (d == D) ? -1 : 0;
        nx = x + dx;
        ny = y + dy;
        legal = (nx >= 0 && nx < GW && ny >= 0 && ny < GH);
        if (wrap) begin
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
            legal = 1'b1;
        end
    endfunction

    // Advance both models by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int tx, ty;
        bit lg, tk;
        for (int i = 0; i < 2; i++) begin
            tk = en && (mc[i] == DIV - 1);
            if (reset) begin
                mx[i] = SX; my[i] = SY; md[i] = W; mq[i] = W; mc[i] = 0; mph[i] = 0;
                mmv[i] = 0; mbl[i] = 0;
            end else begin
                mmv[i] = 0; mbl[i] = 0;
                if (mph[i] == 0) begin
                    if (tk) mph[i] = 1;
                end else if (mph[i] == 1) begin
                    if (mq[i] == W) begin
                        md[i] = W; mph[i] = 0;
                    end else begin
                        nb(mx[i], my[i], mq[i], wrapf[i], tx, ty, lg);
                        if (lg && !wall_at(tx, ty)) begin
                            mx[i] = tx; my[i] = ty; md[i] = mq[i]; mmv[i] = 1; mph[i] = 0;
                        end else begin
                            mph[i] = 2;
                        end
                    end
                end else begin
                    nb(mx[i], my[i], md[i], wrapf[i], tx, ty, lg);
                    if (md[i] != W && lg && !wall_at(tx, ty)) begin
                        mx[i] = tx; my[i] = ty; mmv[i] = 1;
                    end else begin
                        mbl[i] = 1;
                    end
                    mph[i] = 0;
                end
                if (en) mc[i] = (mc[i] + 1) % DIV;
                if (dir_in <= 3'd4) mq[i] = int'(dir_in);
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int i, output int ox, output int oy, output int od,
                           output int omv, output int obl, output int omx, output int omy);
        if (i == 0) begin
            ox = int'(ifa.x_out); oy = int'(ifa.y_out); od = int'(ifa.dir_out);
            omv = int'(ifa.moved); obl = int'(ifa.blocked);
            omx = int'(ifa.map_x); omy = int'(ifa.map_y);
        end else begin
            ox = int'(ifb.x_out); oy = int'(ifb.y_out); od = int'(ifb.dir_out);
            omv = int'(ifb.moved); obl = int'(ifb.blocked);
            omx = int'(ifb.map_x); omy = int'(ifb.map_y);
        end
    endtask

    task automatic compare_all();
        int ox, oy, od, omv, obl, omx, omy, tx, ty;
        bit lg;
        string p;
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? "a" : "b";
            get_obs(i, ox, oy, od, omv, obl, omx, omy);
            chk({p, ".x_out"}, ox, mx[i]);
            chk({p, ".y_out"}, oy, my[i]);
            chk({p, ".dir_out"}, od, md[i]);
            chk({p, ".moved"}, omv, int'(mmv[i]));
            chk({p, ".blocked"}, obl, int'(mbl[i]));
            if (mph[i] == 0) begin
                tx = mx[i]; ty = my[i]; lg = 1'b1;
            end else begin
                nb(mx[i], my[i], (mph[i] == 1) ? mq[i] : md[i], wrapf[i], tx, ty, lg);
            end
            if (lg) begin
                chk({p, ".map_x"}, omx, tx);
                chk({p, ".map_y"}, omy, ty);
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    // Run until instance inst pulses moved; n = cycles taken, -1 on timeout.
    task automatic wait_moved(input int inst, input int bound, output int n);
        int ox, oy, od, omv, obl, omx, omy;
        n = -1;
        for (int k = 0; k < bound; k++) begin
            cycle();
            get_obs(inst, ox, oy, od, omv, obl, omx, omy);
            if (omv == 1) begin
                n = k + 1;
                break;
            end
        end
        chk("moved_seen", int'(n > 0), 1);
    endtask

    initial begin
        int n, cnt_mv, cnt_bl, rx, ry;
        wrapf[0] = 1'b1;
        wrapf[1] = 1'b0;
        walls  = '0;
        reset  = 1'b1;
        en     = 1'b0;
        dir_in = 3'(W);
        @(negedge clock);
        cycle();
        cycle();

        // Reset state
        chk("rst_x", int'(ifa.x_out), SX);
        chk("rst_y", int'(ifa.y_out), SY);
        chk("rst_dir", int'(ifa.dir_out), W);
        chk("rst_moved", int'(ifa.moved), 0);
        chk("rst_blocked", int'(ifb.blocked), 0);

        // First move and step period
        reset = 1'b0; en = 1'b1; dir_in = 3'(R);
        wait_moved(0, 20, n);
        chk("first_lat", n, 5);
        chk("first_x", int'(ifa.x_out), 3);
        chk("first_dir", int'(ifa.dir_out), R);
        wait_moved(0, 10, n);
        chk("period", n, DIV);
        chk("second_x", int'(ifa.x_out), 4);

        // Right edge: wrap on a, block on b
        for (int k = 0; k < 22; k++) wait_moved(0, 10, n);
        chk("edge_a_x", int'(ifa.x_out), 26);
        chk("edge_b_x", int'(ifb.x_out), 26);
        wait_moved(0, 10, n);
        chk("wrap_a_x", int'(ifa.x_out), 0);
        cycle();
        chk("nowrap_b_blocked", int'(ifb.blocked), 1);
        chk("nowrap_b_x", int'(ifb.x_out), 26);

        // Queued turn walled off: go forward, then turn once the cell opens
        reset = 1'b1; cycle(); reset = 1'b0; dir_in = 3'(R);
        for (int k = 0; k < 3; k++) wait_moved(0, 10, n);
        chk("at5_x", int'(ifa.x_out), 5);
        set_wall(5, 2, 1'b1);
        dir_in = 3'(U);
        wait_moved(0, 10, n);
        chk("fwd_lat", n, 5);
        chk("fwd_x", int'(ifa.x_out), 6);
        chk("fwd_dir", int'(ifa.dir_out), R);
        wait_moved(0, 10, n);
        chk("turn_lat", n, 3);
        chk("turn_y", int'(ifa.y_out), 2);
        chk("turn_dir", int'(ifa.dir_out), U);

        // Both queued and current directions walled: blocked each tick
        dir_in = 3'(R);
        wait_moved(0, 10, n);
        chk("at7_x", int'(ifa.x_out), 7);
        set_wall(8, 2, 1'b1);
        set_wall(7, 3, 1'b1);
        dir_in = 3'(U);
        cnt_mv = 0; cnt_bl = 0;
        for (int k = 0; k < 13; k++) begin
            cycle();
            cnt_mv += int'(ifa.moved);
            cnt_bl += int'(ifa.blocked);
        end
        chk("blk_count", cnt_bl, 3);
        chk("blk_moves", cnt_mv, 0);
        chk("blk_x", int'(ifa.x_out), 7);
        chk("blk_y", int'(ifa.y_out), 2);

        // Enable low mid-count
        walls = '0;
        dir_in = 3'(R);
        wait_moved(0, 10, n);
        chk("pre_pause_x", int'(ifa.x_out), 8);
        cycle();
        en = 1'b0;
        cnt_mv = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            cnt_mv += int'(ifa.moved) + int'(ifa.blocked);
        end
        chk("pause_steps", cnt_mv, 0);
        chk("pause_x", int'(ifa.x_out), 8);
        en = 1'b1;
        wait_moved(0, 10, n);
        chk("resume_lat", n, 3);
        chk("resume_x", int'(ifa.x_out), 9);

        // Reset on the forward cycle aborts the step
        set_wall(9, 3, 1'b1);
        dir_in = 3'(U);
        n = 0;
        for (int k = 0; k < 10 && mph[0] != 2; k++) cycle();
        chk("reached_fwd", mph[0], 2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        walls = '0;
        chk("abort_x", int'(ifa.x_out), SX);
        chk("abort_y", int'(ifa.y_out), SY);
        chk("abort_moved", int'(ifa.moved), 0);
        chk("abort_blocked", int'(ifa.blocked), 0);

        // Codes 5-7 leave the queued direction alone
        dir_in = 3'(D);
        cycle();
        dir_in = 3'd7;
        wait_moved(0, 10, n);
        chk("ign7_lat", n, 4);
        chk("ign7_y", int'(ifa.y_out), 0);
        chk("ign7_dir", int'(ifa.dir_out), D);

        // Random phase
        for (int k = 0; k < 600; k++) begin
            dir_in = 3'($urandom_range(0, 7));
            en     = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) begin
                rx = (mx[0] + int'($urandom_range(0, 2)) - 1 + GW) % GW;
                ry = (my[0] + int'($urandom_range(0, 2)) - 1 + GH) % GH;
                set_wall(rx, ry, !wall_at(rx, ry));
            end
            cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
